lsu_rmw_ctrl: RTL and testbench

- Load/store controller between the core datapath (ALU address, rs2 data, funct3) and the word-only data memory.
- Word memory only supports 32-bit word access, so the controller does:
  - byte/half-word loads with sign or zero extension;
  - byte/half-word stores via read-modify-write (RMW);
  - misalignment detection.
- Stalls the core through a single-request handshake until each access completes.

---
 rtl/lsu_pkg.sv | 53 +++++
 rtl/lsu_align.sv | 42 ++++
 rtl/lsu_rmw_ctrl.sv | 133 +++++++++++++
 tb/tb_lsu_rmw_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and decode helpers for the load/store controller.
// Build option: LSU_MISALIGN_TRAP_EN selects trap-on-misalign versus forced alignment.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // Stores only come in signed-width flavours; loads add the unsigned B/H variants.
    function automatic logic f3Legal(input logic isStore, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (isStore) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    function automatic logic f3Misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (f3[1:0])
            2'b01:   bad = lo[0];
            2'b10:   bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [1:0] f3AlignLo(input logic [2:0] f3, input logic [1:0] lo);
        logic [1:0] res;
        res = lo;
        case (f3[1:0])
            2'b01:   res = {lo[1], 1'b0};
            2'b10:   res = 2'b00;
            default: res = lo;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/half lane steering: extends load data from a word and merges store data into a word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addrLo,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_loadData,
    output logic [31:0] o_storeData
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addrLo, 3'b000} +: 8];
    assign w_half = i_word[{i_addrLo[1], 4'b0000} +: 16];

    always_comb begin
        o_loadData = 32'd0;
        case (i_funct3)
            F3_B:    o_loadData = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_loadData = {24'd0, w_byte};
            F3_H:    o_loadData = {{16{w_half[15]}}, w_half};
            F3_HU:   o_loadData = {16'd0, w_half};
            F3_W:    o_loadData = i_word;
            default: o_loadData = 32'd0;
        endcase
    end

    // Sub-word stores keep the untouched lanes of the word read back from memory.
    always_comb begin
        o_storeData = i_word;
        case (i_funct3[1:0])
            2'b00:   o_storeData[{i_addrLo, 3'b000} +: 8] = i_wdata[7:0];
            2'b01:   o_storeData[{i_addrLo[1], 4'b0000} +: 16] = i_wdata[15:0];
            2'b10:   o_storeData = i_wdata;
            default: o_storeData = i_word;
        endcase
    end

endmodule

// File: rtl/lsu_rmw_ctrl.sv
// Load/store controller for a word-only data memory: sub-word loads, RMW sub-word stores, stalls.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module lsu_rmw_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              access_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        r_state;
    lsu_state_e        w_nextState;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [DATA_W-1:0] r_wdata;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;

    logic [ADDR_W-1:0] w_reqAddr;
    logic [ADDR_W-1:0] w_capAddr;
    logic              w_err;
    logic              w_capture;
    logic [DATA_W-1:0] w_loadWord;
    logic [DATA_W-1:0] w_storeWord;
    logic              w_unusedAddrHi;

    assign w_reqAddr      = req_addr[ADDR_W-1:0];
    assign w_unusedAddrHi = ^req_addr[31:ADDR_W];

    always_comb begin
        w_err     = 1'b0;
        w_capAddr = w_reqAddr;
`ifdef LSU_MISALIGN_TRAP_EN
        w_err     = !f3Legal(req_we, req_funct3) ||
                    f3Misaligned(req_funct3, w_reqAddr[1:0]);
        w_capAddr = w_reqAddr;
`else
        w_err     = !f3Legal(req_we, req_funct3);
        w_capAddr = {w_reqAddr[ADDR_W-1:2], f3AlignLo(req_funct3, w_reqAddr[1:0])};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Full-word stores skip the read; sub-word stores read first so lanes can be merged.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_capture = 1'b1;
                    if (w_err) begin
                        w_nextState = DONE;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        w_nextState = WR;
                    end else begin
                        w_nextState = RD;
                    end
                end
            end
            RD:      w_nextState = r_we ? WR : DONE;
            WR:      w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_capture) begin
                r_addr   <= w_capAddr;
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_wdata  <= req_wdata;
                r_err    <= w_err;
            end
            if (r_state == RD) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    lsu_align u_align (
        .i_funct3    (r_funct3),
        .i_addrLo    (r_addr[1:0]),
        .i_word      (r_rdata),
        .i_wdata     (r_wdata),
        .o_loadData  (w_loadWord),
        .o_storeData (w_storeWord)
    );

    // Memory strobes decode straight from state so an async reset kills a pending write at once.
    always_comb begin
        mem_read   = (r_state == RD);
        mem_write  = (r_state == WR);
        mem_addr   = (mem_read || mem_write) ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
        mem_wdata  = mem_write ? w_storeWord : '0;
        stall      = req_valid && (r_state != DONE);
        access_err = (r_state == DONE) && r_err;
        load_data  = ((r_state == DONE) && !r_we && !r_err) ? w_loadWord : '0;
    end

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// Directed bench for lsu_rmw_ctrl with a behavioural word memory; honours LSU_MISALIGN_TRAP_EN.
module tb_lsu_rmw_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        access_err;
    logic        mem_read;
    logic        mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] tbMem [0:127];
    logic        pokeEn;
    logic [6:0]  pokeIdx;
    logic [31:0] pokeVal;

    int assertCount;
    int failCount;
    int overlapCount;

    lsu_rmw_ctrl #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .load_data  (load_data),
        .access_err (access_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = tbMem[mem_addr[8:2]];

    always @(posedge clk) begin
        if (pokeEn) begin
            tbMem[pokeIdx] <= pokeVal;
        end else if (mem_write) begin
            tbMem[mem_addr[8:2]] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_read && mem_write) overlapCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic poke(input logic [6:0] idx, input logic [31:0] val);
        pokeEn  = 1'b1;
        pokeIdx = idx;
        pokeVal = val;
        @(posedge clk);
        #1 pokeEn = 1'b0;
    endtask

    // Caller is 1ns after a rising edge with the DUT in IDLE.
    task automatic runOp(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int expStall, input logic [31:0] expLoad, input logic expErr,
                         input int expReads, input int expWrites,
                         input logic [31:0] expWdata, input logic [8:0] expWaddr,
                         input bit holdAfter);
        int          cycles;
        int          reads;
        int          writes;
        bit          done;
        logic [31:0] loadObs;
        logic        errObs;
        logic [31:0] lastWdata;
        logic [8:0]  lastWaddr;
        cycles = 0; reads = 0; writes = 0; done = 0;
        loadObs = '0; errObs = 1'b0; lastWdata = '0; lastWaddr = '0;
        applyStimulus(we, f3, addr, wdata);
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (stall) begin
                cycles++;
                if (mem_read) reads++;
                if (mem_write) begin
                    writes++;
                    lastWdata = mem_wdata;
                    lastWaddr = mem_addr;
                end
            end else begin
                done    = 1;
                loadObs = load_data;
                errObs  = access_err;
            end
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_stall"}, 32'(cycles), 32'(expStall));
        checkOutput({tag, "_load"}, loadObs, expLoad);
        checkOutput({tag, "_err"}, 32'(errObs), 32'(expErr));
        checkOutput({tag, "_reads"}, 32'(reads), 32'(expReads));
        checkOutput({tag, "_writes"}, 32'(writes), 32'(expWrites));
        if (expWrites > 0) begin
            checkOutput({tag, "_wdata"}, lastWdata, expWdata);
            checkOutput({tag, "_waddr"}, 32'(lastWaddr), 32'(expWaddr));
        end
        @(posedge clk);
        #1;
        if (!holdAfter) req_valid = 1'b0;
    endtask

    initial begin
        assertCount = 0; failCount = 0; overlapCount = 0;
        pokeEn = 1'b0; pokeIdx = '0; pokeVal = '0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0);
        req_valid = 1'b0;
        #1;
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
        checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
        checkOutput("rst_access_err", 32'(access_err), 32'd0);
        checkOutput("rst_load_data", load_data, 32'd0);
        checkOutput("rst_state", 32'(dut.r_state), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        poke(7'd0, 32'h8040_20FF);
        poke(7'd1, 32'h1122_3344);
        poke(7'd2, 32'hCAFE_F00D);

        runOp("lb0", 1'b0, 3'b000, 32'h0, 32'h0, 2, 32'hFFFF_FFFF, 1'b0, 1, 0, 32'h0, 9'h0, 1'b0);
        runOp("lbu3", 1'b0, 3'b100, 32'h3, 32'h0, 2, 32'h0000_0080, 1'b0, 1, 0, 32'h0, 9'h0, 1'b0);
        runOp("sb5", 1'b1, 3'b000, 32'h5, 32'h0000_00AB, 3, 32'h0, 1'b0, 1, 1,
              32'h1122_AB44, 9'h004, 1'b0);
        checkOutput("sb5_mem", tbMem[1], 32'h1122_AB44);

        poke(7'd1, 32'h1122_3344);
        runOp("sh6", 1'b1, 3'b001, 32'h6, 32'h0000_BEEF, 3, 32'h0, 1'b0, 1, 1,
              32'hBEEF_3344, 9'h004, 1'b0);
        runOp("lhu6", 1'b0, 3'b101, 32'h6, 32'h0, 2, 32'h0000_BEEF, 1'b0, 1, 0, 32'h0, 9'h0, 1'b0);
        runOp("lh6", 1'b0, 3'b001, 32'h6, 32'h0, 2, 32'hFFFF_BEEF, 1'b0, 1, 0, 32'h0, 9'h0, 1'b0);
        runOp("lb7", 1'b0, 3'b000, 32'h7, 32'h0, 2, 32'hFFFF_FFBE, 1'b0, 1, 0, 32'h0, 9'h0, 1'b0);
        runOp("lh_hiaddr", 1'b0, 3'b001, 32'hFFFF_FE04, 32'h0, 2, 32'h0000_3344, 1'b0, 1, 0,
              32'h0, 9'h0, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
        runOp("lw2_trap", 1'b0, 3'b010, 32'h2, 32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0, 9'h0, 1'b0);
        runOp("sh5_trap", 1'b1, 3'b001, 32'h5, 32'h1234, 1, 32'h0, 1'b1, 0, 0, 32'h0, 9'h0, 1'b0);
`else
        runOp("lw2_align", 1'b0, 3'b010, 32'h2, 32'h0, 2, 32'h8040_20FF, 1'b0, 1, 0,
              32'h0, 9'h0, 1'b0);
        runOp("lh7_align", 1'b0, 3'b001, 32'h7, 32'h0, 2, 32'hFFFF_BEEF, 1'b0, 1, 0,
              32'h0, 9'h0, 1'b0);
`endif
        runOp("ld_ill011", 1'b0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0, 9'h0, 1'b0);
        runOp("st_ill100", 1'b1, 3'b100, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 0, 32'h0, 9'h0, 1'b0);

        @(negedge clk);
        checkOutput("idle_quiet", {29'd0, stall, mem_read, mem_write}, 32'd0);
        @(posedge clk);
        #1;

        // Reset while the SB write strobe is up.
        applyStimulus(1'b1, 3'b000, 32'h8, 32'h0000_0055);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rstwr_write_up", 32'(mem_write), 32'd1);
        checkOutput("rstwr_wdata", mem_wdata, 32'hCAFE_F055);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstwr_write_drop", 32'(mem_write), 32'd0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstwr_mem_kept", tbMem[2], 32'hCAFE_F00D);
        rst_n = 1'b1;
        #1;
        checkOutput("rstwr_state", 32'(dut.r_state), 32'd0);
        checkOutput("rstwr_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;

        runOp("sw10", 1'b1, 3'b010, 32'h10, 32'h1357_9BDF, 2, 32'h0, 1'b0, 0, 1,
              32'h1357_9BDF, 9'h010, 1'b1);
        runOp("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h1357_9BDF, 1'b0, 1, 0,
              32'h0, 9'h0, 1'b0);

        checkOutput("no_rw_overlap", 32'(overlapCount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
